aes_result_tx: RTL and testbench

AES_RESULT_TX -- requirements
Module: aes_result_tx

---
 rtl/aes_result_tx.sv | 119 +++++++++++
 tb/tb_aes_result_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/aes_result_tx.sv
// rtl/aes_result_tx.sv - frames a captured AES result set (header, cipher, plain, status) as a byte stream.
// Defining AES_RESULT_TX_CHECKSUM_EN appends a trailing XOR checksum byte (CSUM).
module aes_result_tx (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   bits,
    input  logic [127:0] cipher_in,
    input  logic [127:0] plain_in,
    input  logic [127:0] ref_in,
    output logic         busy,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_last,
    output logic         match,
    output logic         done,
    output logic         reject
);

`ifdef AES_RESULT_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, CIPH, PLN, STAT, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, CIPH, PLN, STAT} state_t;
`endif

    state_t       state, next_state;
    logic [3:0]   cnt;
    logic [1:0]   bits_q;
    logic [127:0] ciph_q;
    logic [127:0] pln_q;
    logic         cmp_q;
`ifdef AES_RESULT_TX_CHECKSUM_EN
    logic [7:0]   csum;
`endif

    logic       fire;
    logic       capture;
    logic [6:0] bit_idx;

    assign fire    = tx_valid && tx_ready;
    assign capture = (state == IDLE) && start && (bits != 2'd3);
    // Byte 0 of a block is [127:120], so the slice base is 8*(15-cnt).
    assign bit_idx = {~cnt, 3'b000};

    always_comb begin
        next_state = state;
        tx_valid   = (state != IDLE);
        busy       = (state != IDLE);
        tx_data    = 8'h00;
        tx_last    = 1'b0;
        case (state)
            IDLE: begin
                if (capture) next_state = HDR;
            end
            HDR: begin
                tx_data = {6'b101001, bits_q};
                if (fire) next_state = CIPH;
            end
            CIPH: begin
                tx_data = ciph_q[bit_idx +: 8];
                if (fire && cnt == 4'd15) next_state = PLN;
            end
            PLN: begin
                tx_data = pln_q[bit_idx +: 8];
                if (fire && cnt == 4'd15) next_state = STAT;
            end
            STAT: begin
                tx_data = {7'b0, cmp_q};
`ifdef AES_RESULT_TX_CHECKSUM_EN
                if (fire) next_state = CSUM;
            end
            CSUM: begin
                tx_data = csum;
                tx_last = 1'b1;
                if (fire) next_state = IDLE;
`else
                tx_last = 1'b1;
                if (fire) next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            bits_q <= 2'd0;
            ciph_q <= 128'd0;
            pln_q  <= 128'd0;
            cmp_q  <= 1'b0;
            match  <= 1'b0;
            done   <= 1'b0;
            reject <= 1'b0;
`ifdef AES_RESULT_TX_CHECKSUM_EN
            csum   <= 8'h00;
`endif
        end else begin
            state  <= next_state;
            done   <= fire && tx_last;
            reject <= (state == IDLE) && start && (bits == 2'd3);
            if (capture) begin
                bits_q <= bits;
                ciph_q <= cipher_in;
                pln_q  <= plain_in;
                cmp_q  <= (plain_in == ref_in);
            end
            if (fire && (state == CIPH || state == PLN)) cnt <= cnt + 4'd1;
            if (fire && tx_last) match <= cmp_q;
`ifdef AES_RESULT_TX_CHECKSUM_EN
            if (capture) csum <= 8'h00;
            else if (fire) csum <= csum ^ tx_data;
`endif
        end
    end

endmodule

// File: tb/tb_aes_result_tx.sv
// tb/tb_aes_result_tx.sv - table-driven bench for aes_result_tx with backpressure, reject and reset sequences.
module tb_aes_result_tx;

`ifdef AES_RESULT_TX_CHECKSUM_EN
    localparam int NB = 35;
`else
    localparam int NB = 34;
`endif

    logic         clock = 1'b0;
    logic         reset, start, tx_ready;
    logic [1:0]   bits;
    logic [127:0] cipher_in, plain_in, ref_in;
    logic         busy, tx_valid, tx_last, match, done, reject;
    logic [7:0]   tx_data;

    aes_result_tx dut (
        .clock(clock), .reset(reset), .start(start), .bits(bits),
        .cipher_in(cipher_in), .plain_in(plain_in), .ref_in(ref_in),
        .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .match(match), .done(done), .reject(reject)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   bits;
        logic [127:0] cipher;
        logic [127:0] plain;
        logic [127:0] refv;
        logic [7:0]   hdr;
        logic         exp_match;
        int           stall_at;
        int           stall_len;
        int           busy_at;
    } vec_t;

    vec_t vt[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int v, input int k);
        logic [7:0] x;
        if (k == 0) return vt[v].hdr;
        if (k <= 16) return vt[v].cipher[127 - 8*(k-1) -: 8];
        if (k <= 32) return vt[v].plain[127 - 8*(k-17) -: 8];
        if (k == 33) return {7'b0, vt[v].exp_match};
        x = 8'h00;
        for (int i = 0; i < 34; i++) x = x ^ exp_byte(v, i);
        return x;
    endfunction

    task automatic run_frame(input int v);
        int n, cyc, stalls;
        bits = vt[v].bits; cipher_in = vt[v].cipher; plain_in = vt[v].plain; ref_in = vt[v].refv;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // Scramble the inputs so the frame can only come from captured data
        bits = 2'd3; cipher_in = ~cipher_in; plain_in = ~plain_in; ref_in = ~ref_in;
        check("busy_after_start", busy, 1'b1);
        n = 0; cyc = 1; stalls = 0;
        while (n < NB && cyc < 200) begin
            check("tx_valid", tx_valid, 1'b1);
            check("tx_data", tx_data, exp_byte(v, n));
            check("tx_last", tx_last, (n == NB-1));
            check("done_low", done, 1'b0);
            check("reject_low", reject, 1'b0);
            if (n == vt[v].stall_at && stalls < vt[v].stall_len) begin
                tx_ready = 1'b0;
                stalls++;
            end else begin
                tx_ready = 1'b1;
            end
            if (n == vt[v].busy_at) begin
                start = 1'b1;
                bits  = 2'd0;
            end
            if (tx_valid && tx_ready) n++;
            @(posedge clock); #1;
            start = 1'b0;
            bits  = 2'd3;
            cyc++;
        end
        tx_ready = 1'b1;
        check("frame_complete", n, NB);
        check("done_pulse", done, 1'b1);
        check("tx_valid_drop", tx_valid, 1'b0);
        check("busy_drop", busy, 1'b0);
        check("match", match, vt[v].exp_match);
        check("frame_cycles", cyc, NB + 1 + vt[v].stall_len);
    endtask

    initial begin
        vt[0] = '{2'd0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff,
                  128'h00112233445566778899aabbccddeeff, 8'hA4, 1'b1, -1, 0, -1};
        vt[1] = '{2'd0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff,
                  128'h0, 8'hA4, 1'b0, -1, 0, -1};
        vt[2] = '{2'd1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff,
                  128'h00112233445566778899aabbccddeeff, 8'hA5, 1'b1, 4, 3, -1};
        vt[3] = '{2'd2, 128'h8ea2b7ca516745bfeafc49904b496089, 128'hffeeddccbbaa99887766554433221100,
                  128'hffeeddccbbaa99887766554433221100, 8'hA6, 1'b1, -1, 0, 6};

        reset = 1'b1; start = 1'b0; tx_ready = 1'b1; bits = 2'd0;
        cipher_in = '0; plain_in = '0; ref_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_last", tx_last, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_reject", reject, 1'b0);
        check("rst_match", match, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Frames run back to back: each new start lands on the previous done cycle
        for (int v = 0; v < 4; v++) run_frame(v);

        // Illegal key size
        @(posedge clock); #1;
        bits = 2'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("reject_pulse", reject, 1'b1);
        check("reject_tx_valid", tx_valid, 1'b0);
        check("reject_busy", busy, 1'b0);
        @(posedge clock); #1;
        check("reject_one_cycle", reject, 1'b0);
        check("reject_idle", tx_valid, 1'b0);

        // Reset at byte 10, asserted together with start
        bits = 2'd0; cipher_in = vt[0].cipher; plain_in = vt[0].plain; ref_in = vt[0].refv;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock); #1;
        end
        check("pre_reset_byte10", tx_data, exp_byte(0, 9));
        reset = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        check("midrst_tx_valid", tx_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_tx_last", tx_last, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_match", match, 1'b0);
        @(posedge clock); #1;
        check("midrst_no_done", done, 1'b0);
        check("midrst_still_idle", busy, 1'b0);
        run_frame(0);

        @(posedge clock); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
